bnn_mem_responder: RTL



---
 rtl/bnn_mem_responder_pkg.sv | 31 +++
 rtl/bnn_mem_responder_if.sv | 30 +++
 rtl/bnn_mem_responder_mem_bank.sv | 30 +++
 rtl/bnn_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bnn_mem_responder_pkg.sv
// bnn_mem_pkg: shared definitions for the BNN memory responder.
//   - rw command encodings (idle/read/write/illegal)
//   - sticky error codes
//   - responder state encoding (CLEAR / READY)
//   - sat_inc: saturating 32-bit increment used by the optional access
//     counters (ACCESS_CNT_EN)
package bnn_mem_pkg;

  typedef enum logic [1:0] {
    RW_IDLE    = 2'b00,
    RW_READ    = 2'b01,
    RW_WRITE   = 2'b10,
    RW_ILLEGAL = 2'b11
  } rw_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_RW    = 2'b10
  } err_code_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bnn_mem_responder_if.sv
// bnn_mem_responder_if: fetch bus between the compute engine (master) and a
// memory responder (slave).
//   master drives : addr, sel, rw, wdata
//   slave drives  : rdata, rvalid, ready, err, err_code
interface bnn_mem_responder_if #(
  parameter int ADDR_LEN = 10,
  parameter int DATA_LEN = 1,
  parameter int SEL_LEN  = 2,
  parameter int RW_LEN   = 2
);
  logic [ADDR_LEN-1:0] addr;
  logic [SEL_LEN-1:0]  sel;
  logic [RW_LEN-1:0]   rw;
  logic [DATA_LEN-1:0] wdata;
  logic [DATA_LEN-1:0] rdata;
  logic                rvalid;
  logic                ready;
  logic                err;
  logic [1:0]          err_code;

  modport master (
    output addr, sel, rw, wdata,
    input  rdata, rvalid, ready, err, err_code
  );

  modport slave (
    input  addr, sel, rw, wdata,
    output rdata, rvalid, ready, err, err_code
  );
endinterface

// File: rtl/bnn_mem_responder_mem_bank.sv
// mem_bank: single-port synchronous RAM, DEPTH x DATA_LEN.
//   clk   : clock
//   we    : write enable (mem[addr] <= wdata)
//   re    : read enable  (rdata register <= mem[addr])
//   addr  : word address
//   wdata : write data
//   rdata : registered read data; holds until the next enabled read
// The caller never asserts we and re together, so no collision rule is needed.
module mem_bank #(
  parameter int DEPTH    = 784,
  parameter int ADDR_LEN = 10,
  parameter int DATA_LEN = 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata
);
  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [DATA_LEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/bnn_mem_responder.sv
// bnn_mem_responder: memory-side responder for the compute engine fetch bus.
// After reset a clear sequencer writes zero to every word of all banks
// (DEPTH cycles), then requests are served from NUM_BANKS = 2**SEL_LEN banks.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bnn_mem_responder_if.slave (addr/sel/rw/wdata in,
//              rdata/rvalid/ready/err/err_code out)
//   rd_cnt, wr_cnt : saturating counts of accepted in-range reads / writes,
//              present only when ACCESS_CNT_EN is defined
module bnn_mem_responder
  import bnn_mem_pkg::*;
#(
  parameter int ADDR_LEN = 10,
  parameter int DEPTH    = 784,
  parameter int DATA_LEN = 1,
  parameter int SEL_LEN  = 2,
  parameter int RW_LEN   = 2
) (
  input  logic clk,
  input  logic rst,
  bnn_mem_responder_if.slave bus
`ifdef ACCESS_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);
  localparam int NUM_BANKS = 2 ** SEL_LEN;
  localparam logic [ADDR_LEN:0]   DEPTH_W   = (ADDR_LEN + 1)'(DEPTH);
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(DEPTH - 1);

  // ---------------- clear sequencer FSM ----------------
  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] clear_ptr_q, clear_ptr_d;
  logic                ready, clearing;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      CLEAR: begin
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == LAST_ADDR) begin
          state_d     = READY;
          clear_ptr_d = '0;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_comb begin
    ready    = (state_q == READY);
    clearing = (state_q == CLEAR);
  end

  // ---------------- request decode ----------------
  logic in_range, is_rd, is_wr, is_ill, rd_ok, wr_ok, rd_oor, wr_oor;

  always_comb begin
    in_range = ({1'b0, bus.addr} < DEPTH_W);
    is_rd    = ready && (bus.rw == RW_READ);
    is_wr    = ready && (bus.rw == RW_WRITE);
    is_ill   = ready && (bus.rw == RW_ILLEGAL);
    rd_ok    = is_rd && in_range;
    wr_ok    = is_wr && in_range;
    rd_oor   = is_rd && !in_range;
    wr_oor   = is_wr && !in_range;
  end

  // ---------------- banks ----------------
  logic [ADDR_LEN-1:0]  bank_addr;
  logic [DATA_LEN-1:0]  bank_wdata;
  logic [NUM_BANKS-1:0] bank_we, bank_re;
  logic [DATA_LEN-1:0]  bank_rdata [NUM_BANKS];

  // While clearing, every bank is written with zero at clear_ptr in parallel.
  always_comb begin
    bank_addr  = clearing ? clear_ptr_q : bus.addr;
    bank_wdata = clearing ? '0 : bus.wdata;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign bank_we[gi] = clearing || (wr_ok && (bus.sel == SEL_LEN'(gi)));
      assign bank_re[gi] = rd_ok && (bus.sel == SEL_LEN'(gi));

      mem_bank #(
        .DEPTH   (DEPTH),
        .ADDR_LEN(ADDR_LEN),
        .DATA_LEN(DATA_LEN)
      ) u_bank (
        .clk  (clk),
        .we   (bank_we[gi]),
        .re   (bank_re[gi]),
        .addr (bank_addr),
        .wdata(bank_wdata),
        .rdata(bank_rdata[gi])
      );
    end
  endgenerate

  // ---------------- read response ----------------
  // rdata is steered from the bank that served the last read. Bank read
  // registers only change on their own reads, so the mux output holds between
  // reads. last_zero_q forces 0 after reset and after an out-of-range read.
  logic               rvalid_q, rvalid_d;
  logic               last_zero_q, last_zero_d;
  logic [SEL_LEN-1:0] last_sel_q, last_sel_d;

  always_comb begin
    rvalid_d    = rd_ok || rd_oor;
    last_zero_d = last_zero_q;
    last_sel_d  = last_sel_q;
    if (rd_ok) begin
      last_zero_d = 1'b0;
      last_sel_d  = bus.sel;
    end else if (rd_oor) begin
      last_zero_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q    <= 1'b0;
      last_zero_q <= 1'b1;
      last_sel_q  <= '0;
    end else begin
      rvalid_q    <= rvalid_d;
      last_zero_q <= last_zero_d;
      last_sel_q  <= last_sel_d;
    end
  end

  // ---------------- sticky error latch ----------------
  logic      err_q, err_d;
  err_code_e err_code_q, err_code_d;

  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (!err_q) begin
      if (is_ill) begin
        err_d      = 1'b1;
        err_code_d = ERR_RW;
      end else if (rd_oor || wr_oor) begin
        err_d      = 1'b1;
        err_code_d = ERR_RANGE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.rdata    = last_zero_q ? '0 : bank_rdata[last_sel_q];
  assign bus.rvalid   = rvalid_q;
  assign bus.ready    = ready;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

`ifdef ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_ok ? sat_inc(rd_cnt_q) : rd_cnt_q;
    wr_cnt_d = wr_ok ? sat_inc(wr_cnt_q) : wr_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule
